nrzi_rx_decoder: RTL and testbench
==================================

# nrzi_rx_decoder

Receive-side stage directly downstream of `circuito12`: it takes the same `k`/`j`/`rx_en` line symbols plus the sync detector's `synced_d`/`sync_err_d` indications. Once sync is reported, it NRZI-decodes the symbol stream, removes stuffed bits, assembles LSB-first bytes and flags end-of-packet and protocol errors. It turns the sync detector's output into a byte stream for the packet layer.

## Interface
- `MAX_BYTES`, default 64: maximum payload bytes per packet; one more completed byte is an overflow.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `k`  in  1  line symbol K component.
- `j`  in  1  line symbol J component.
- `rx_en`  in  1  symbol-valid qualifier; `k`/`j` are sampled only when high.
- `synced_d`  in  1  one-cycle pulse from the sync detector; the sync pattern ended on a K symbol.
- `sync_err_d`  in  1  one-cycle pulse from the sync detector; the sync pattern failed.
- `data`  out  8  assembled byte, valid while `data_valid`=1.
- `data_valid`  out  1  one-cycle pulse per completed byte.
- `eop`  out  1  one-cycle pulse on a clean end-of-packet.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  3  valid with `err`: 1 = stuff error, 2 = SE1 line state, 3 = partial byte at EOP, 4 = overflow.
- `busy`  out  1  high while in the RECV state.

## Operation
- **Line state decode** (only when `rx_en`=1):
  - J = `j`&!`k`
  - K = `k`&!`j`
  - SE0 = !`j`&!`k`
  - SE1 = `j`&`k`
- **States:** IDLE and RECV.
- **IDLE:**
  - On `synced_d`=1, go to RECV.
  - On entry: prev_state=K, bit_cnt=0, ones_cnt=0, byte_cnt=0, shift register cleared.
  - Symbols are ignored.
- **RECV**, per sampled J/K symbol:
  - bit = 1 if the symbol equals prev_state, else 0; then prev_state = symbol.
  - If ones_cnt=6, the bit is a stuffed bit:
    - bit 0: discard it and set ones_cnt=0.
    - bit 1: pulse `err` with code 1, go to IDLE.
  - Otherwise shift the bit in at bit 7 (LSB first). ones_cnt = bit ? ones_cnt+1 : 0. Increment bit_cnt.
  - On the 8th data bit:
    - Drive `data`, pulse `data_valid`, set bit_cnt=0, increment byte_cnt.
    - If byte_cnt was already `MAX_BYTES`, pulse `err` with code 4 instead of `data_valid` and go to IDLE.
- **RECV, SE0 symbol:**
  - bit_cnt=0: pulse `eop`.
  - bit_cnt≠0: pulse `err` with code 3; the partial bits are discarded.
  - Either case: go to IDLE.
- **RECV, SE1 symbol:** pulse `err` with code 2, go to IDLE.
- **`sync_err_d`=1 in any state:** go to IDLE with no output pulse. It has priority over `synced_d` in the same cycle.
- **`synced_d`=1 while in RECV:** silent restart. Re-initialise exactly as on entry from IDLE; partial data is dropped and no error is raised.
- **`rx_en`=0:** all state holds; `k`/`j` are ignored.
- `rx_en` does not gate `synced_d` or `sync_err_d`.

## Timing
- All outputs are registered.
- Reset values: `data`=0, `data_valid`=0, `eop`=0, `err`=0, `err_code`=0, `busy`=0, state=IDLE.
- Reset applied mid-packet: all outputs read 0 the cycle after the reset edge; the packet is abandoned.
- Latency:
  - `data_valid`/`eop`/`err` assert in the cycle after the edge that samples the completing symbol.
  - Every one of these pulses lasts exactly one cycle.
- `data` holds its last value between pulses. `err_code` returns to 0 when `err` is low.
- `busy` rises the cycle after `synced_d` is sampled and falls the cycle after the terminating event.
- Max one of `data_valid`/`eop`/`err` per cycle.
- Back-to-back symbols (`rx_en` high every cycle) are supported at full rate.

## Test plan
- **Byte 0xA5 then EOP:** `synced_d` pulse, then symbols K,J,J,K,J,J,K,K,SE0 with `rx_en`=1 → `data`=0xA5 with one `data_valid` pulse, then `eop`=1 one cycle later; `busy` low afterwards.
- **Bit stuffing:** `synced_d`, then K×6, J, J, J, SE0 → `data`=0xFF. The stuffed J is discarded; `eop` clean, no `err`.
- **Stuff error:** `synced_d`, then K×7 → `err`=1 with `err_code`=1 after the 7th K; IDLE, no `data_valid`.
- **Partial byte and SE1:**
  - `synced_d`, K,J,J, SE0 → `err_code`=3.
  - Repeat with SE1 (`j`=`k`=1) instead of SE0 → `err_code`=2.
- **`rx_en` gaps and sync abort:**
  - Insert `rx_en`=0 cycles with garbage `k`/`j` inside the 0xA5 sequence → identical result to the gap-free run.
  - A `sync_err_d` pulse mid-byte → IDLE, no pulses. Following symbols are ignored until the next `synced_d`.
- **Overflow and reset:**
  - With `MAX_BYTES`=2, send three 0x00 bytes (symbols alternating from K) → two `data_valid` pulses, then `err_code`=4.
  - Separately, assert `rst` mid-byte → all outputs 0 next cycle; later symbols without `synced_d` produce nothing.

Source files
------------

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: after a sync indication, turns J/K line symbols into
// destuffed LSB-first bytes, and flags end-of-packet and line/protocol errors.
module nrzi_rx_decoder #(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k,
  input  logic       j,
  input  logic       rx_en,
  input  logic       synced_d,
  input  logic       sync_err_d,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       eop,
  output logic       err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int unsigned       BCW          = (MAX_BYTES < 1) ? 1 : $clog2(MAX_BYTES + 1);
  localparam logic [BCW-1:0]    BYTE_LIMIT   = BCW'(MAX_BYTES);
  localparam logic [2:0]        STUFF_RUN    = 3'd6;
  localparam logic [2:0]        LAST_BIT     = 3'd7;
  localparam logic [2:0]        ERR_STUFF    = 3'd1;
  localparam logic [2:0]        ERR_SE1      = 3'd2;
  localparam logic [2:0]        ERR_PARTIAL  = 3'd3;
  localparam logic [2:0]        ERR_OVERFLOW = 3'd4;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t         state_q, state_d;
  logic           prev_k_q, prev_k_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]     ones_cnt_q, ones_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           data_valid_q, data_valid_d;
  logic           eop_q, eop_d;
  logic           err_q, err_d;
  logic [2:0]     err_code_q, err_code_d;

  logic       sym_j, sym_k, sym_se0, sym_se1;
  logic       rx_bit;
  logic [7:0] shift_in;

  assign sym_j   = rx_en &  j & ~k;
  assign sym_k   = rx_en &  k & ~j;
  assign sym_se0 = rx_en & ~j & ~k;
  assign sym_se1 = rx_en &  j &  k;

  // NRZI: an unchanged line level carries a 1, a transition carries a 0.
  assign rx_bit   = (sym_k == prev_k_q);
  assign shift_in = {rx_bit, shift_q[7:1]};

  always_comb begin
    state_d      = state_q;
    prev_k_d     = prev_k_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    eop_d        = 1'b0;
    err_d        = 1'b0;
    err_code_d   = '0;

    if (sync_err_d) begin
      state_d = IDLE;
    end else if (synced_d) begin
      state_d    = RECV;
      prev_k_d   = 1'b1;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (state_q == RECV) begin
      if (sym_j || sym_k) begin
        prev_k_d = sym_k;
        if (ones_cnt_q == STUFF_RUN) begin
          if (rx_bit) begin
            err_d      = 1'b1;
            err_code_d = ERR_STUFF;
            state_d    = IDLE;
          end else begin
            ones_cnt_d = '0;
          end
        end else begin
          shift_d    = shift_in;
          ones_cnt_d = rx_bit ? (ones_cnt_q + 3'd1) : 3'd0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == BYTE_LIMIT) begin
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
              state_d    = IDLE;
            end else begin
              data_d       = shift_in;
              data_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + BCW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end else if (sym_se0) begin
        if (bit_cnt_q == 3'd0) begin
          eop_d = 1'b1;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_PARTIAL;
        end
        state_d = IDLE;
      end else if (sym_se1) begin
        err_d      = 1'b1;
        err_code_d = ERR_SE1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_k_q     <= 1'b1;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_k_q     <= prev_k_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      eop_q        <= eop_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign eop        = eop_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q == RECV);

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Bench for nrzi_rx_decoder: directed scenarios plus random packets built by a
// reference NRZI/bit-stuffing encoder; decoded events are compared per packet.
module tb_nrzi_rx_decoder;

  localparam int S_J = 0, S_K = 1, S_SE0 = 2, S_SE1 = 3;
  localparam int EV_DATA = 32'h100, EV_EOP = 32'h200, EV_ERR = 32'h300;

  logic clk = 1'b0;
  logic rst, k, j, rx_en, sync1, serr1, sync2, serr2;
  logic [7:0] data1, data2;
  logic dv1, eop1, err1, busy1, dv2, eop2, err2, busy2;
  logic [2:0] code1, code2;
  logic dv1_p, eop1_p, err1_p, dv2_p, eop2_p, err2_p;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;
  int obs1[$], obs2[$], exp_q[$], sym_q[$];

  always #5 clk = ~clk;

  nrzi_rx_decoder dut1 (
    .clk(clk), .rst(rst), .k(k), .j(j), .rx_en(rx_en),
    .synced_d(sync1), .sync_err_d(serr1),
    .data(data1), .data_valid(dv1), .eop(eop1), .err(err1),
    .err_code(code1), .busy(busy1)
  );

  nrzi_rx_decoder #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .k(k), .j(j), .rx_en(rx_en),
    .synced_d(sync2), .sync_err_d(serr2),
    .data(data2), .data_valid(dv2), .eop(eop2), .err(err2),
    .err_code(code2), .busy(busy2)
  );

  // Event recorder; also flags overlapping or stretched pulses and stray err_code.
  always @(negedge clk) begin
    if (dv1)  obs1.push_back(EV_DATA | int'(data1));
    if (eop1) obs1.push_back(EV_EOP);
    if (err1) obs1.push_back(EV_ERR | int'(code1));
    if (dv2)  obs2.push_back(EV_DATA | int'(data2));
    if (eop2) obs2.push_back(EV_EOP);
    if (err2) obs2.push_back(EV_ERR | int'(code2));
    if ((dv1 & eop1) | (dv1 & err1) | (eop1 & err1) | (!err1 && code1 != 3'd0)) proto_viol++;
    if ((dv2 & eop2) | (dv2 & err2) | (eop2 & err2) | (!err2 && code2 != 3'd0)) proto_viol++;
    if ((dv1 & dv1_p) | (eop1 & eop1_p) | (err1 & err1_p)) proto_viol++;
    if ((dv2 & dv2_p) | (eop2 & eop2_p) | (err2 & err2_p)) proto_viol++;
    dv1_p <= dv1; eop1_p <= eop1; err1_p <= err1;
    dv2_p <= dv2; eop2_p <= eop2; err2_p <= err2;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int s);
    @(negedge clk);
    sync1 = 0; serr1 = 0; sync2 = 0; serr2 = 0; rx_en = 1;
    case (s)
      S_J:     begin k = 0; j = 1; end
      S_K:     begin k = 1; j = 0; end
      S_SE0:   begin k = 0; j = 0; end
      default: begin k = 1; j = 1; end
    endcase
  endtask

  task automatic gap();
    @(negedge clk);
    sync1 = 0; serr1 = 0; sync2 = 0; serr2 = 0; rx_en = 0;
    k = 1'($urandom_range(0, 1)); j = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse(input bit to2, input bit s, input bit e);
    gap();
    if (to2) begin sync2 = s; serr2 = e; end
    else     begin sync1 = s; serr1 = e; end
  endtask

  task automatic send_q(input bit gaps);
    foreach (sym_q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) gap();
      drive(sym_q[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1; rx_en = 0; k = 0; j = 0;
    sync1 = 0; serr1 = 0; sync2 = 0; serr2 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data1); end
    checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", dv1); end
    checks++; if (eop1 !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", eop1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err1); end
    checks++; if (code1 !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", code1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    @(negedge clk); rst = 0;
    settle(2);
  endtask

  task automatic settle(input int n);
    repeat (n) gap();
  endtask

  task automatic test_a5();
    obs1.delete();
    pulse(0, 1, 0);
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL a5_busy_rise got %b want 1", busy1); end
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K};
    send_q(0);
    @(posedge clk); #1;
    checks++; if (dv1 !== 1'b1) begin errors++; $display("FAIL a5_dv_latency got %b want 1", dv1); end
    checks++; if (data1 !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", data1); end
    drive(S_SE0);
    @(posedge clk); #1;
    checks++; if (eop1 !== 1'b1 || dv1 !== 1'b0) begin errors++; $display("FAIL a5_eop got eop=%b dv=%b want eop=1 dv=0", eop1, dv1); end
    gap();
    @(posedge clk); #1;
    checks++; if (eop1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL a5_after got eop=%b busy=%b want 0 0", eop1, busy1); end
    checks++; if (data1 !== 8'hA5) begin errors++; $display("FAIL a5_data_hold got %h want a5", data1); end
    settle(2);
    exp_q = '{EV_DATA | 32'hA5, EV_EOP};
    checks++;
    if (obs1.size() !== exp_q.size()) begin errors++; $display("FAIL a5_count got %0d want %0d", obs1.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (obs1[i] !== exp_q[i]) begin errors++; $display("FAIL a5_ev%0d got %h want %h", i, obs1[i], exp_q[i]); end
    end
  endtask

  task automatic test_directed(input string name, input bit gaps, input int exp_busy);
    obs1.delete();
    pulse(0, 1, 0);
    send_q(gaps);
    settle(3);
    checks++; if (busy1 !== 1'(exp_busy)) begin errors++; $display("FAIL %s_busy got %b want %0d", name, busy1, exp_busy); end
    checks++;
    if (obs1.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, obs1.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (obs1[i] !== exp_q[i]) begin errors++; $display("FAIL %s_ev%0d got %h want %h", name, i, obs1[i], exp_q[i]); end
    end
  endtask

  task automatic test_stuffing();
    sym_q = '{S_K, S_K, S_K, S_K, S_K, S_K, S_J, S_J, S_J, S_SE0};
    exp_q = '{EV_DATA | 32'hFF, EV_EOP};
    test_directed("stuff", 0, 0);
    sym_q = '{S_K, S_K, S_K, S_K, S_K, S_K, S_K};
    exp_q = '{EV_ERR | 1};
    test_directed("stuff_err", 0, 0);
  endtask

  task automatic test_partial_se1();
    sym_q = '{S_K, S_J, S_J, S_SE0};
    exp_q = '{EV_ERR | 3};
    test_directed("partial", 0, 0);
    sym_q = '{S_K, S_J, S_J, S_SE1};
    exp_q = '{EV_ERR | 2};
    test_directed("se1", 0, 0);
  endtask

  task automatic test_gaps();
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_SE0};
    exp_q = '{EV_DATA | 32'hA5, EV_EOP};
    test_directed("gaps", 1, 0);
  endtask

  task automatic test_sync_abort();
    obs1.delete();
    pulse(0, 1, 0);
    sym_q = '{S_K, S_J, S_J};
    send_q(0);
    pulse(0, 0, 1);
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy1); end
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_SE0};
    send_q(1);
    pulse(0, 1, 1);
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_prio_busy got %b want 0", busy1); end
    send_q(0);
    settle(3);
    checks++; if (obs1.size() !== 0) begin errors++; $display("FAIL abort_events got %0d want 0", obs1.size()); end
  endtask

  task automatic test_restart();
    obs1.delete();
    pulse(0, 1, 0);
    sym_q = '{S_K, S_J, S_J, S_K};
    send_q(0);
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_SE0};
    exp_q = '{EV_DATA | 32'hA5, EV_EOP};
    test_directed("restart", 0, 0);
  endtask

  task automatic test_overflow();
    obs2.delete();
    pulse(1, 1, 0);
    sym_q.delete();
    for (int i = 0; i < 24; i++) sym_q.push_back((i % 2 == 0) ? S_J : S_K);
    sym_q.push_back(S_SE0);
    send_q(0);
    settle(3);
    exp_q = '{EV_DATA, EV_DATA, EV_ERR | 4};
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL ovf_busy got %b want 0", busy2); end
    checks++;
    if (obs2.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d want %0d", obs2.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (obs2[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_ev%0d got %h want %h", i, obs2[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    pulse(0, 1, 0);
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_K, S_J};
    send_q(0);
    @(negedge clk);
    rx_en = 0; rst = 1;
    @(posedge clk); #1;
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", data1); end
    checks++; if ({dv1, eop1, err1} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses got %b want 000", {dv1, eop1, err1}); end
    checks++; if (code1 !== 3'd0 || busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_code_busy got %0d %b want 0 0", code1, busy1); end
    @(negedge clk); rst = 0;
    obs1.delete();
    sym_q = '{S_K, S_J, S_J, S_K, S_J, S_J, S_K, S_K, S_SE0};
    send_q(0);
    settle(3);
    checks++; if (obs1.size() !== 0 || busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_after got events=%0d busy=%b want 0 0", obs1.size(), busy1); end
  endtask

  // Reference encoder: bytes LSB-first, a 0 inserted after every six 1s, then
  // NRZI from an initial K level (1 = hold level, 0 = toggle).
  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int nb, term, extra, run, lvl;
      byte unsigned pl[$];
      bit bits[$];
      byte unsigned b;
      nb = $urandom_range(0, 5);
      term = $urandom_range(0, 2);
      pl.delete(); bits.delete(); sym_q.delete(); exp_q.delete();
      for (int n = 0; n < nb; n++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        pl.push_back(b);
        exp_q.push_back(EV_DATA | int'(b));
      end
      foreach (pl[i]) for (int n = 0; n < 8; n++) bits.push_back(pl[i][n]);
      extra = (term == 0) ? 0 : (term == 1) ? $urandom_range(1, 7) : $urandom_range(0, 7);
      for (int n = 0; n < extra; n++) bits.push_back($urandom_range(0, 3) != 0);
      run = 0; lvl = S_K;
      foreach (bits[i]) begin
        if (!bits[i]) lvl = (lvl == S_K) ? S_J : S_K;
        sym_q.push_back(lvl);
        run = bits[i] ? run + 1 : 0;
        if (run == 6) begin
          lvl = (lvl == S_K) ? S_J : S_K;
          sym_q.push_back(lvl);
          run = 0;
        end
      end
      sym_q.push_back((term == 2) ? S_SE1 : S_SE0);
      exp_q.push_back((term == 0) ? EV_EOP : (term == 1) ? (EV_ERR | 3) : (EV_ERR | 2));
      obs1.delete();
      pulse(0, 1, 0);
      send_q(it[0]);
      settle(3);
      checks++;
      if (obs1.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, obs1.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin
        checks++; if (obs1[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_ev%0d got %h want %h", it, i, obs1[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_viol !== 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_stuffing();
    test_partial_se1();
    test_gaps();
    test_sync_abort();
    test_restart();
    test_overflow();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
